// File: rtl/alu_pkg.sv
// Shared encodings for the registered ALU: opcodes,
// SLT compare modes and the control FSM states.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  localparam logic [2:0] CMP_LT = 3'b000;
  localparam logic [2:0] CMP_GT = 3'b001;
  localparam logic [2:0] CMP_LE = 3'b010;
  localparam logic [2:0] CMP_GE = 3'b011;
  localparam logic [2:0] CMP_EQ = 3'b100;
  localparam logic [2:0] CMP_NE = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between decode, the ALU
// and the writeback mux.
interface alu_seq_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       ALU_control;
  logic [2:0]       bonus_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, src1, src2,
    output ALU_control, bonus_control,
    output out_ready,
    input  in_ready, out_valid, result,
    input  zero, cout, overflow, illegal
  );

  modport slave (
    input  in_valid, src1, src2,
    input  ALU_control, bonus_control,
    input  out_ready,
    output in_ready, out_valid, result,
    output zero, cout, overflow, illegal
  );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit
// per cycle, LSB first, 2*WIDTH-bit accumulator.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] a_sh;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_sh;
  logic [CW-1:0]      cnt;
  logic               run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      a_sh <= {{WIDTH{1'b0}}, a};
      b_sh <= b;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b1;
    end else if (run) begin
      acc  <= acc + (b_sh[0] ? a_sh : '0);
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CW'(1);
      if (cnt == LAST)
        run <= 1'b0;
    end
  end

  // done marks the cycle whose edge folds in the last bit
  assign busy    = run;
  assign done    = run && (cnt == LAST);
  assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides and
// a multi-cycle unsigned multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  state_t state_q, state_d;

  logic [WIDTH-1:0]   a, b;
  logic [3:0]         op;
  logic [2:0]         bc;
  logic [WIDTH:0]     sum, diff;
  logic               ov_add, ov_sub;
  logic               lt, eq, cmp, cmp_ok;
  logic [WIDTH-1:0]   res_d;
  logic               cout_d, ov_d, ill_d;
  logic               is_mul;
  logic               accept, drain;
  logic               load, load_mul, mul_start;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH-1:0]   res_q;
  logic               out_valid_q;
  logic               zero_q, cout_q, ov_q, ill_q;

  assign a  = bus.src1;
  assign b  = bus.src2;
  assign op = bus.ALU_control;
  assign bc = bus.bonus_control;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b}
              + {{WIDTH{1'b0}}, 1'b1};

  assign ov_add = (a[WIDTH-1] == b[WIDTH-1])
               && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ov_sub = (a[WIDTH-1] != b[WIDTH-1])
               && (diff[WIDTH-1] != a[WIDTH-1]);
  assign lt = diff[WIDTH-1] ^ ov_sub;
  assign eq = (a == b);

  always_comb begin
    cmp    = 1'b0;
    cmp_ok = 1'b1;
    unique case (1'b1)
      bc == CMP_LT: cmp = lt;
      bc == CMP_GT: cmp = !lt && !eq;
      bc == CMP_LE: cmp = lt || eq;
      bc == CMP_GE: cmp = !lt;
      bc == CMP_EQ: cmp = eq;
      bc == CMP_NE: cmp = !eq;
      default:      cmp_ok = 1'b0;
    endcase
  end

  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    ov_d   = 1'b0;
    ill_d  = 1'b0;
    is_mul = 1'b0;
    unique case (1'b1)
      op == OP_AND:  res_d = a & b;
      op == OP_OR:   res_d = a | b;
      op == OP_NOR:  res_d = ~(a | b);
      op == OP_NAND: res_d = ~(a & b);
      op == OP_ADD: begin
        res_d  = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
        ov_d   = ov_add;
      end
      op == OP_SUB: begin
        res_d  = diff[WIDTH-1:0];
        cout_d = diff[WIDTH];
        ov_d   = ov_sub;
      end
      op == OP_SLT: begin
        if (cmp_ok) begin
          res_d  = {{(WIDTH-1){1'b0}}, cmp};
          cout_d = diff[WIDTH];
          ov_d   = ov_sub;
        end else begin
          ill_d = 1'b1;
        end
      end
      (op == OP_MUL) && MUL_EN: is_mul = 1'b1;
      default: ill_d = 1'b1;
    endcase
  end

  assign bus.in_ready = rst_n
                     && (state_q == S_IDLE)
                     && !mul_busy
                     && (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign drain  = out_valid_q && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_mul  = 1'b0;
    mul_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else begin
            load = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (mul_done)
          state_d = S_DONE;
      end
      S_DONE: begin
        load_mul = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ov_q        <= 1'b0;
      ill_q       <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      res_q       <= res_d;
      zero_q      <= (res_d == '0);
      cout_q      <= cout_d;
      ov_q        <= ov_d;
      ill_q       <= ill_d;
    end else if (load_mul) begin
      out_valid_q <= 1'b1;
      res_q       <= product[WIDTH-1:0];
      zero_q      <= (product[WIDTH-1:0] == '0);
      cout_q      <= 1'b0;
      ov_q        <= |product[2*WIDTH-1:WIDTH];
      ill_q       <= 1'b0;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ov_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32: flags,
// handshake, multiply latency, backpressure, reset.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(
    .WIDTH  (32),
    .MUL_EN (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_asrt = 0;
  int n_fail = 0;
  int lat;
  bit rdy_bad;
  bit stale;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [31:0] res,
                         input logic z, c, o, il);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".res"},   64'(bus.result),    64'(res));
    chk({tag, ".zero"},  64'(bus.zero),      64'(z));
    chk({tag, ".cout"},  64'(bus.cout),      64'(c));
    chk({tag, ".ovf"},   64'(bus.overflow),  64'(o));
    chk({tag, ".ill"},   64'(bus.illegal),   64'(il));
  endtask

  task automatic drive(input logic [3:0] op,
                       input logic [2:0] bc,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.in_valid      = 1'b1;
    bus.ALU_control   = op;
    bus.bonus_control = bc;
    bus.src1          = a;
    bus.src2          = b;
  endtask

  task automatic op1(input logic [3:0] op,
                     input logic [2:0] bc,
                     input logic [31:0] a,
                     input logic [31:0] b);
    drive(op, bc, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic mul_run(input logic [31:0] a,
                         input logic [31:0] b,
                         output int l,
                         output bit bad);
    drive(OP_MUL, 3'b000, a, b);
    @(negedge clk);
    // offered while busy: must be ignored
    drive(OP_ADD, 3'b000, 32'h5, 32'h7);
    l = 0;
    bad = 1'b0;
    while (!bus.out_valid && l < 64) begin
      if (bus.in_ready) bad = 1'b1;
      if (l == 20) bus.in_valid = 1'b0;
      @(negedge clk);
      l++;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.src1          = '0;
    bus.src2          = '0;
    bus.ALU_control   = '0;
    bus.bonus_control = '0;

    @(negedge clk);
    @(negedge clk);
    chk("rst.in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.result",    64'(bus.result),    64'd0);
    chk("rst.zero",      64'(bus.zero),      64'd0);
    chk("rst.cout",      64'(bus.cout),      64'd0);
    chk("rst.ovf",       64'(bus.overflow),  64'd0);
    chk("rst.ill",       64'(bus.illegal),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel.in_ready", 64'(bus.in_ready), 64'd1);

    bus.out_ready = 1'b1;
    op1(OP_ADD, 3'b000, 32'h7FFF_FFFF, 32'h1);
    chk_out("add_ovf", 32'h8000_0000, 0, 0, 1, 0);

    drive(OP_SUB, 3'b000, 32'd5, 32'd5);
    chk("b2b.rdy0", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    chk_out("sub_eq", 32'h0, 1, 1, 0, 0);
    chk("b2b.rdy1", 64'(bus.in_ready), 64'd1);
    drive(OP_ADD, 3'b000, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("add_wrap", 32'h0, 1, 1, 0, 0);
    chk("b2b.rdy2", 64'(bus.in_ready), 64'd1);

    op1(OP_SLT, CMP_LT, 32'hFFFF_FFFF, 32'h1);
    chk_out("slt_lt", 32'h1, 0, 1, 0, 0);
    op1(OP_SLT, CMP_GT, 32'hFFFF_FFFF, 32'h1);
    chk_out("slt_gt", 32'h0, 1, 1, 0, 0);
    op1(OP_SLT, CMP_EQ, 32'hFFFF_FFFF, 32'h1);
    chk_out("slt_eq", 32'h0, 1, 1, 0, 0);
    op1(OP_SLT, 3'b110, 32'hFFFF_FFFF, 32'h1);
    chk_out("slt_bad", 32'h0, 1, 0, 0, 1);
    op1(OP_SLT, CMP_GE, 32'h3, 32'h3);
    chk_out("slt_ge", 32'h1, 0, 1, 0, 0);

    op1(4'b0011, 3'b000, 32'h1234, 32'h1);
    chk_out("op_bad", 32'h0, 1, 0, 0, 1);
    op1(OP_OR, 3'b000, 32'hF0, 32'h0F);
    chk_out("or", 32'hFF, 0, 0, 0, 0);
    op1(OP_NOR, 3'b000, 32'h0, 32'h0);
    chk_out("nor", 32'hFFFF_FFFF, 0, 0, 0, 0);
    op1(OP_NAND, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_out("nand", 32'h0, 1, 0, 0, 0);
    op1(OP_SUB, 3'b000, 32'h8000_0000, 32'h1);
    chk_out("sub_ovf", 32'h7FFF_FFFF, 0, 1, 1, 0);

    mul_run(32'h0001_0000, 32'h0001_0000, lat, rdy_bad);
    chk("mul1.lat", 64'(lat), 64'd33);
    chk("mul1.rdy", 64'(rdy_bad), 64'd0);
    chk_out("mul1", 32'h0, 1, 0, 1, 0);

    mul_run(32'd1234, 32'd5678, lat, rdy_bad);
    chk("mul2.lat", 64'(lat), 64'd33);
    chk_out("mul2", 32'd7006652, 0, 0, 0, 0);

    op1(OP_AND, 3'b000, 32'hF0F0, 32'hFF00);
    bus.out_ready = 1'b0;
    chk_out("bp0", 32'hF000, 0, 0, 0, 0);
    drive(OP_OR, 3'b000, 32'h1, 32'h2);
    repeat (3) @(negedge clk);
    chk_out("bp_hold", 32'hF000, 0, 0, 0, 0);
    chk("bp.rdy", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("bp_rel", 32'h3, 0, 0, 0, 0);

    drive(OP_MUL, 3'b000, 32'd3, 32'd3);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.valid",  64'(bus.out_valid), 64'd0);
    chk("ar.result", 64'(bus.result),    64'd0);
    chk("ar.zero",   64'(bus.zero),      64'd0);
    chk("ar.cout",   64'(bus.cout),      64'd0);
    chk("ar.ovf",    64'(bus.overflow),  64'd0);
    chk("ar.ill",    64'(bus.illegal),   64'd0);
    chk("ar.rdy",    64'(bus.in_ready),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar.rdy_rel", 64'(bus.in_ready), 64'd1);
    stale = 1'b0;
    repeat (40) begin
      if (bus.out_valid) stale = 1'b1;
      @(negedge clk);
    end
    chk("ar.stale", 64'(stale), 64'd0);
    op1(OP_ADD, 3'b000, 32'd2, 32'd3);
    chk_out("ar_add", 32'd5, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 32-bit combinational ALU in COLab1.
- Keeps the ALU_control and bonus_control encodings and the zero/cout/overflow flags.
- Adds WIDTH generalisation, valid/ready handshakes on both sides, a registered result, and a multi-cycle unsigned shift-add multiply.
- Sits between the decode stage and the writeback mux of the lab CPU datapath.

Parameters:
- WIDTH, 32, operand and result width in bits, must be >= 4.
- MUL_EN, 1, 1 enables the MUL opcode; 0 makes MUL illegal.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request is valid.
- in_ready  output  1  block can accept a request this cycle.
- src1  input  WIDTH  operand A.
- src2  input  WIDTH  operand B.
- ALU_control  input  4  opcode.
- bonus_control  input  3  compare mode for SLT.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow (ADD/SUB) or product overflow (MUL).
- illegal  output  1  opcode unsupported; result forced to 0.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE.
  - out_valid, result, zero, cout, overflow, illegal all = 0.
  - in_ready = 0 while reset is asserted; it is 1 in the first cycle after release.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A + ~B + 1); 1100 NOR; 1101 NAND; 0111 SLT; 1000 MUL.
  - Any other code is illegal.
- SLT compare modes, signed, selected by bonus_control: 000 A<B, 001 A>B, 010 A<=B, 011 A>=B, 100 A==B, 101 A!=B.
  - 110 and 111 are illegal.
  - Result is {WIDTH-1 zeros, cmp}.
  - cmp for the ordered modes comes from sign(A-B) XOR overflow(A-B).
- Flags:
  - cout and overflow are valid for ADD, SUB and SLT (taken from the subtract); 0 for logic ops.
  - MUL: cout = 0; overflow = 1 iff the upper WIDTH bits of the 2*WIDTH-bit unsigned product are nonzero.
  - zero is always computed from the registered result.
- Handshake:
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
  - A request is accepted on a clock edge where in_valid && in_ready.
  - out_valid stays high, with result and flags held stable, until out_valid && out_ready.
  - Acceptance and drain may occur on the same edge; this gives back-to-back single-cycle ops at full throughput.
- FSM states and transitions:
  - IDLE:
    - Single-cycle op accepted: result registered on that edge, out_valid = 1 next cycle (latency 1).
    - MUL accepted: latch operands, clear accumulator, counter = 0, go to MUL.
  - MUL:
    - One multiplier bit per cycle, LSB first.
    - Counter wraps at WIDTH-1; at that point go to DONE.
  - DONE:
    - Load result, overflow and zero; set out_valid; go to IDLE.
    - Total MUL latency from acceptance to out_valid is WIDTH+1 cycles.
- Input sampling and state:
  - in_ready = 0 during MUL and DONE; inputs presented then are ignored.
  - Operands are sampled only on acceptance; later changes to src1/src2 have no effect.
- Illegal opcode: single-cycle completion with illegal = 1, result = 0, zero = 1, cout = 0, overflow = 0.
- Reset mid-MUL: aborts immediately; no out_valid is produced for the aborted request.
- Width rule: all arithmetic is modulo 2^WIDTH, except the MUL accumulator, which is 2*WIDTH bits.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_NAND, OP_SLT, OP_MUL);
  - compare-mode localparams (CMP_LT … CMP_NE);
  - FSM state encoding (S_IDLE, S_MUL, S_DONE).
- Sub-module alu_mul_seq (parameter WIDTH) is the shift-add multiplier:
  - inputs: start, a, b;
  - outputs: busy, done pulse, 2*WIDTH product.
- alu_seq owns the handshake, the single-cycle datapath and the output register.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF + 0x00000001, out_ready = 1 → result 0x80000000, overflow 1, cout 0, zero 0, out_valid one cycle after acceptance.
- SUB 5 − 5 followed back-to-back by ADD 0xFFFFFFFF + 1 → first result 0, zero 1, cout 1; second result 0, cout 1, overflow 0, zero 1; in_ready stays high throughout.
- SLT with A = 0xFFFFFFFF (−1), B = 1:
  - bonus 000 → 1; bonus 001 → 0; bonus 100 → 0; bonus 110 → illegal 1, result 0.
- MUL 0x00010000 × 0x00010000 → result 0, overflow 1, zero 1, out_valid 33 cycles after acceptance, in_ready low during those cycles.
  - MUL 1234 × 5678 → 7006652, overflow 0.
- Backpressure: hold out_ready = 0 after an AND 0xF0F0 & 0xFF00 → result stays 0xF000 and out_valid stays 1; in_ready = 0 with in_valid = 1; releasing out_ready drains the result and accepts the next request on the same edge.
- Assert rst_n = 0 at cycle 10 of a MUL → all outputs 0 asynchronously; after release, no stale out_valid and in_ready = 1.
